hpu_seq: RTL and testbench

Job sequencer for the HPU datapath: on a single start command it latches the job configuration, drives `gen` for exactly the programmed number of item-memory cycles, then drives `run` until the output stream has delivered its last beat. It sits between the AXI-Lite register file and the stream datapath (`get_ctrl`, `stream_ctrl`, `buffer_ctrl`, `core`, `xorshift`). It replaces host-timed `run`/`gen` writes and the fixed `addr_i`, `addr_j` and item-count constants.

---
 rtl/hpu_seq_if.sv | 51 +++++
 rtl/hpu_seq.sv | 132 +++++++++++++
 tb/tb_hpu_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hpu_seq_if.sv
`timescale 1ns/1ps
// hpu_seq_if: groups the job-sequencer control and status signals.
//   master : host/datapath side. Drives config pulses, get_fin and the
//            M_AXIS handshake monitor, and observes the status outputs.
//   slave  : the sequencer (hpu_seq).
// Signals:
//   cfg_start/cfg_abort        one-cycle command pulses
//   cfg_item_num               item-memory vector count (CNT_W)
//   cfg_addr_i/cfg_addr_j      loop bounds to latch (ADDR_W)
//   get_fin                    input consumption finished pulse
//   dst_valid/ready/last       output stream handshake monitor
//   gen/run                    datapath enables
//   item_a                     item-memory write address
//   addr_i/addr_j              latched loop bounds
//   busy/done/aborted          job status
//   run_cycles                 saturating RUN+DRAIN cycle count
interface hpu_seq_if #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 20
);
  logic              cfg_start;
  logic              cfg_abort;
  logic [CNT_W-1:0]  cfg_item_num;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic [ADDR_W-1:0] cfg_addr_j;
  logic              get_fin;
  logic              dst_valid;
  logic              dst_ready;
  logic              dst_last;
  logic              gen;
  logic              run;
  logic [CNT_W-1:0]  item_a;
  logic [ADDR_W-1:0] addr_i;
  logic [ADDR_W-1:0] addr_j;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [31:0]       run_cycles;

  modport master (
    output cfg_start, cfg_abort, cfg_item_num, cfg_addr_i, cfg_addr_j,
           get_fin, dst_valid, dst_ready, dst_last,
    input  gen, run, item_a, addr_i, addr_j, busy, done, aborted, run_cycles
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_item_num, cfg_addr_i, cfg_addr_j,
           get_fin, dst_valid, dst_ready, dst_last,
    output gen, run, item_a, addr_i, addr_j, busy, done, aborted, run_cycles
  );
endinterface

// File: rtl/hpu_seq.sv
`timescale 1ns/1ps
// hpu_seq: HPU job sequencer.
// On a start pulse it latches the job config, drives gen for exactly
// cfg_item_num cycles (item_a = 0..N-1), then drives run through RUN and
// DRAIN until the last output beat is accepted. Abort returns to IDLE.
// Ports:
//   clk  datapath clock
//   rst  asynchronous, active-high reset
//   bus  hpu_seq_if.slave (config/handshake inputs, status outputs)
// All outputs are registered; gen/run/busy are decoded from the next state
// so they change on the same edge as the state itself.
module hpu_seq #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 20
) (
  input logic       clk,
  input logic       rst,
  hpu_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_item_a;
  logic [ADDR_W-1:0] r_addr_i;
  logic [ADDR_W-1:0] r_addr_j;
  logic [31:0]       r_run_cycles;
  logic              r_gen;
  logic              r_run;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic w_start;
  logic w_abort;
  logic w_last_beat;
  logic w_gen_end;
  logic w_in_run;

  // Abort beats start when both arrive together; abort in IDLE is a no-op.
  assign w_abort     = bus.cfg_abort && (r_state != S_IDLE);
  assign w_start     = bus.cfg_start && !bus.cfg_abort &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_beat = bus.dst_valid && bus.dst_ready && bus.dst_last;
  assign w_gen_end   = (r_item_a == r_count - CNT_W'(1));
  assign w_in_run    = (r_state == S_RUN) || (r_state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking for all clocked state so every register samples
      // pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_start)
        w_state_nxt = (bus.cfg_item_num != '0) ? S_GEN : S_RUN;
      S_GEN:   if (w_gen_end)    w_state_nxt = S_RUN;
      S_RUN:   if (bus.get_fin)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_beat)  w_state_nxt = S_DONE;
      default:                   w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_item_a     <= '0;
      r_addr_i     <= '0;
      r_addr_j     <= '0;
      r_run_cycles <= '0;
      r_gen        <= 1'b0;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_gen  <= (w_state_nxt == S_GEN);
      r_run  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_busy <= (w_state_nxt == S_GEN) || (w_state_nxt == S_RUN) ||
                (w_state_nxt == S_DRAIN);
      if (w_start) begin
        r_addr_i     <= bus.cfg_addr_i;
        r_addr_j     <= bus.cfg_addr_j;
        r_count      <= bus.cfg_item_num;
        r_item_a     <= '0;
        r_run_cycles <= '0;
        r_done       <= 1'b0;
        r_aborted    <= 1'b0;
      end else if (w_abort) begin
        // item_a and run_cycles freeze so the host can see how far it got.
        r_aborted <= 1'b1;
        r_done    <= 1'b0;
      end else begin
        // item_a stops at count-1 on the last GEN cycle and holds there.
        if ((r_state == S_GEN) && !w_gen_end)
          r_item_a <= r_item_a + CNT_W'(1);
        if (w_in_run && (r_run_cycles != 32'hFFFF_FFFF))
          r_run_cycles <= r_run_cycles + 32'd1;
        if ((r_state == S_DRAIN) && w_last_beat)
          r_done <= 1'b1;
      end
    end
  end

  assign bus.gen        = r_gen;
  assign bus.run        = r_run;
  assign bus.item_a     = r_item_a;
  assign bus.addr_i     = r_addr_i;
  assign bus.addr_j     = r_addr_j;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.aborted    = r_aborted;
  assign bus.run_cycles = r_run_cycles;

endmodule

// File: tb/tb_hpu_seq.sv
`timescale 1ns/1ps
// tb_hpu_seq: directed scenarios plus randomized traffic for hpu_seq,
// compared every cycle against a job-level reference model.
module tb_hpu_seq;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpu_seq_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  hpu_seq #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: job described by remaining gen cycles, a running flag
  // and whether get_fin has been seen; DONE is simply "done flag set".
  int                m_gen_left;
  bit                m_running;
  bit                m_fin;
  bit                m_done;
  bit                m_aborted;
  logic [31:0]       m_cycles;
  logic [CNT_W-1:0]  m_item;
  logic [ADDR_W-1:0] m_ai;
  logic [ADDR_W-1:0] m_aj;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_gen_left = 0;
    m_running  = 1'b0;
    m_fin      = 1'b0;
    m_done     = 1'b0;
    m_aborted  = 1'b0;
    m_cycles   = '0;
    m_item     = '0;
    m_ai       = '0;
    m_aj       = '0;
  endtask

  task automatic model_edge();
    bit active;
    bit beat;
    if (rst) begin
      model_reset();
      return;
    end
    active = (m_gen_left > 0) || m_running;
    beat   = bus.dst_valid && bus.dst_ready && bus.dst_last;
    if (bus.cfg_abort && (active || m_done)) begin
      m_gen_left = 0;
      m_running  = 1'b0;
      m_aborted  = 1'b1;
      m_done     = 1'b0;
    end else if (bus.cfg_start && !active) begin
      m_ai       = bus.cfg_addr_i;
      m_aj       = bus.cfg_addr_j;
      m_gen_left = int'(bus.cfg_item_num);
      m_running  = (bus.cfg_item_num == '0);
      m_fin      = 1'b0;
      m_item     = '0;
      m_cycles   = '0;
      m_done     = 1'b0;
      m_aborted  = 1'b0;
    end else if (m_gen_left > 0) begin
      m_gen_left--;
      if (m_gen_left == 0) m_running = 1'b1;
      else                 m_item    = m_item + CNT_W'(1);
    end else if (m_running) begin
      if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
      if (!m_fin) begin
        if (bus.get_fin) m_fin = 1'b1;
      end else if (beat) begin
        m_running = 1'b0;
        m_done    = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("gen",        bus.gen,        64'(m_gen_left > 0));
    check("run",        bus.run,        64'(m_running));
    check("busy",       bus.busy,       64'((m_gen_left > 0) || m_running));
    check("done",       bus.done,       64'(m_done));
    check("aborted",    bus.aborted,    64'(m_aborted));
    check("item_a",     bus.item_a,     64'(m_item));
    check("addr_i",     bus.addr_i,     64'(m_ai));
    check("addr_j",     bus.addr_j,     64'(m_aj));
    check("run_cycles", bus.run_cycles, 64'(m_cycles));
  endtask

  task automatic clear_inputs();
    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    bus.get_fin   = 1'b0;
    bus.dst_valid = 1'b0;
    bus.dst_ready = 1'b0;
    bus.dst_last  = 1'b0;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    clear_inputs();
  endtask

  task automatic start_job(input int n, input int ai, input int aj);
    bus.cfg_item_num = CNT_W'(n);
    bus.cfg_addr_i   = ADDR_W'(ai);
    bus.cfg_addr_j   = ADDR_W'(aj);
    bus.cfg_start    = 1'b1;
    step();
  endtask

  initial begin
    int gen_cnt;
    clear_inputs();
    bus.cfg_item_num = '0;
    bus.cfg_addr_i   = '0;
    bus.cfg_addr_j   = '0;
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    step();

    // Long generation phase: gen exactly 1000 cycles, run follows seamlessly.
    start_job(1000, 299, 2);
    gen_cnt = bus.gen ? 1 : 0;
    for (int i = 0; i < 1005; i++) begin
      step();
      if (bus.gen) gen_cnt++;
    end
    check("gen_len_1000", 64'(gen_cnt), 64'd1000);
    check("addr_i_299", bus.addr_i, 64'd299);
    check("addr_j_2", bus.addr_j, 64'd2);
    bus.cfg_abort = 1'b1;
    step();

    // N=0: straight to RUN; get_fin in the 51st RUN cycle, last beat in the
    // 10th DRAIN cycle -> 61 cycles counted.
    start_job(0, 11, 12);
    check("n0_gen", bus.gen, 64'd0);
    check("n0_run", bus.run, 64'd1);
    for (int i = 0; i < 50; i++) begin
      bus.dst_valid = 1'b1;
      bus.dst_ready = 1'($urandom_range(0, 1));
      bus.dst_last  = (i == 20);
      if (i == 20) bus.dst_ready = 1'b1;
      step();
    end
    bus.get_fin = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      bus.dst_valid = 1'b1;
      bus.dst_ready = 1'b1;
      step();
    end
    bus.dst_valid = 1'b1;
    bus.dst_ready = 1'b1;
    bus.dst_last  = 1'b1;
    step();
    check("rc_61", bus.run_cycles, 64'd61);
    check("rc_done", bus.done, 64'd1);
    check("rc_run_low", bus.run, 64'd0);

    // Start accepted straight from DONE; abort in GEN at item_a=37.
    start_job(100, 5, 6);
    repeat (37) step();
    check("gen_at_37", bus.item_a, 64'd37);
    bus.cfg_abort = 1'b1;
    step();
    check("abort_item_hold", bus.item_a, 64'd37);
    check("abort_flag", bus.aborted, 64'd1);
    check("abort_idle", bus.busy, 64'd0);
    step();
    start_job(3, 40, 41);
    check("restart_clears_aborted", bus.aborted, 64'd0);

    // Start during RUN is ignored; start+abort in GEN aborts.
    repeat (3) step();
    bus.cfg_start  = 1'b1;
    bus.cfg_addr_i = ADDR_W'(777);
    bus.cfg_addr_j = ADDR_W'(888);
    step();
    check("busy_start_addr_i", bus.addr_i, 64'd40);
    check("busy_start_run", bus.run, 64'd1);
    bus.cfg_abort = 1'b1;
    step();
    start_job(10, 50, 51);
    step();
    bus.cfg_start  = 1'b1;
    bus.cfg_abort  = 1'b1;
    bus.cfg_addr_i = ADDR_W'(99);
    step();
    check("start_abort_busy", bus.busy, 64'd0);
    check("start_abort_flag", bus.aborted, 64'd1);
    check("start_abort_addr", bus.addr_i, 64'd50);

    // Async reset while in DRAIN, then a normal job afterwards.
    start_job(2, 7, 8);
    repeat (2) step();
    bus.get_fin = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_run",   bus.run,   64'd0);
    check("rst_busy",  bus.busy,  64'd0);
    check("rst_rc",    bus.run_cycles, 64'd0);
    check("rst_addr",  bus.addr_i, 64'd0);
    step();
    rst = 1'b0;
    start_job(4, 3, 4);
    repeat (4) step();
    bus.get_fin = 1'b1;
    step();
    bus.dst_valid = 1'b1;
    bus.dst_ready = 1'b1;
    bus.dst_last  = 1'b1;
    step();
    check("post_rst_done", bus.done, 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.cfg_start    = ($urandom_range(0, 7) == 0);
      bus.cfg_abort    = ($urandom_range(0, 39) == 0);
      bus.cfg_item_num = CNT_W'($urandom_range(0, 12));
      bus.cfg_addr_i   = ADDR_W'($urandom);
      bus.cfg_addr_j   = ADDR_W'($urandom);
      bus.get_fin      = ($urandom_range(0, 5) == 0);
      bus.dst_valid    = 1'($urandom_range(0, 1));
      bus.dst_ready    = 1'($urandom_range(0, 1));
      bus.dst_last     = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
